// File: rtl/linear_mac_reader_if.sv
// linear_mac_reader_if: handshake and weight-ROM signal bundle for the
// dense-layer MAC reader.
//   slave  : the reader (computes the layer)
//   master : the environment (feature producer, weight ROM, result consumer)
interface linear_mac_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              start;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] weight_addr;
  logic [DATA_W-1:0] weight_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              done;

  modport slave (
    input  start, in_valid, in_data, weight_data, out_ready,
    output busy, in_ready, weight_addr, out_valid, out_data, out_idx, done
  );

  modport master (
    output start, in_valid, in_data, weight_data, out_ready,
    input  busy, in_ready, weight_addr, out_valid, out_data, out_idx, done
  );
endinterface

// File: rtl/linear_mac_reader.sv
// linear_mac_reader: one dense-layer pass y[o] = sum_i x[i]*W[o*IN_DIM+i].
// Buffers IN_DIM streamed features, walks the weight ROM linearly (address
// simply increments from 0 to IN_DIM*OUT_DIM-1), accumulates 1.7.24 products
// in an ACC_W-bit signed accumulator and streams OUT_DIM results.
// Optional build macro: LINEAR_MAC_SAT_EN clamps the scaled result to the
// DATA_W signed range; without it the result is a plain wrapping bit-slice.
module linear_mac_reader #(
  parameter int IN_DIM  = 40,
  parameter int OUT_DIM = 10,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int FRAC    = 24,
  parameter int ACC_W   = 64
) (
  input logic                clk,
  input logic                rst,
  linear_mac_reader_if.slave io_bus
);

  localparam int IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int OW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int PW = 2 * DATA_W;
  localparam int SW = ACC_W - FRAC;

  localparam logic [IW-1:0]     I_LAST   = IW'(IN_DIM - 1);
  localparam logic [OW-1:0]     O_LAST   = OW'(OUT_DIM - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(IN_DIM * OUT_DIM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_OUT
  } state_t;

  // Full-precision signed product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] f_mul_ext(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PW-1:0] p;
    p = PW'(a) * PW'(b);
    return ACC_W'(p);
  endfunction

`ifdef LINEAR_MAC_SAT_EN
  // sh is acc >>> FRAC (low fraction bits already dropped, floor rounding).
  // Any disagreement among the bits above the result's sign bit means the
  // value does not fit in DATA_W signed: clamp toward the accumulator sign.
  function automatic logic [DATA_W-1:0] f_scale(input logic signed [SW-1:0] sh);
    logic [SW-DATA_W:0] hi;
    hi = sh[SW-1:DATA_W-1];
    if ((&hi) || (~|hi)) begin
      return sh[DATA_W-1:0];
    end else if (sh[SW-1]) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
  endfunction
`else
  // Already the slice acc[FRAC+DATA_W-1:FRAC]; overflow simply wraps.
  function automatic logic [DATA_W-1:0] f_scale(input logic signed [DATA_W-1:0] sh);
    return sh;
  endfunction
`endif

  state_t                    r_state;
  logic [IW-1:0]             r_i;
  logic [OW-1:0]             r_o;
  logic                      r_busy;
  logic                      r_in_ready;
  logic [ADDR_W-1:0]         r_weight_addr;
  logic                      r_out_valid;
  logic [DATA_W-1:0]         r_out_data;
  logic [ADDR_W-1:0]         r_out_idx;
  logic                      r_done;

  logic signed [DATA_W-1:0]  r_x [IN_DIM];

  // Stage p1: ROM data for the address issued one cycle earlier arrives.
  logic                      r_vld_p1;
  logic [IW-1:0]             r_i_p1;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   w_prod_p1;
  logic signed [ACC_W-1:0]   w_acc_p1;
  logic [DATA_W-1:0]         w_scaled_p1;

  assign w_prod_p1 = f_mul_ext(io_bus.weight_data, r_x[r_i_p1]);
  assign w_acc_p1  = r_vld_p1 ? (r_acc + w_prod_p1) : r_acc;

`ifdef LINEAR_MAC_SAT_EN
  assign w_scaled_p1 = f_scale(w_acc_p1[ACC_W-1:FRAC]);
`else
  assign w_scaled_p1 = f_scale(w_acc_p1[FRAC+DATA_W-1:FRAC]);
`endif

  // Feature buffer: capture x[i] on each accepted input word (no reset needed).
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD && io_bus.in_valid) begin
      r_x[r_i] <= io_bus.in_data;
    end
  end

  // Frame sequencer: load, per-neuron MAC sweep, drain and result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_i           <= '0;
      r_o           <= '0;
      r_busy        <= 1'b0;
      r_in_ready    <= 1'b0;
      r_weight_addr <= '0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_idx     <= '0;
      r_done        <= 1'b0;
      r_vld_p1      <= 1'b0;
      r_i_p1        <= '0;
      r_acc         <= '0;
    end else begin
      r_done   <= 1'b0;
      // Issue flag and feature index follow the ROM's one-cycle read latency.
      r_vld_p1 <= (r_state == S_MAC);
      r_i_p1   <= r_i;
      r_acc    <= w_acc_p1;

      unique case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_i        <= '0;
            r_o        <= '0;
          end
        end

        S_LOAD: begin
          if (io_bus.in_valid) begin
            if (r_i == I_LAST) begin
              r_state       <= S_MAC;
              r_in_ready    <= 1'b0;
              r_i           <= '0;
              r_acc         <= '0;
              r_weight_addr <= '0;
            end else begin
              r_i <= r_i + IW'(1);
            end
          end
        end

        // weight_addr already holds o*IN_DIM+i for this cycle.
        S_MAC: begin
          if (r_i == I_LAST) begin
            r_state <= S_DRAIN;
          end else begin
            r_i           <= r_i + IW'(1);
            r_weight_addr <= r_weight_addr + ADDR_W'(1);
          end
        end

        // Last product lands this cycle; publish the scaled sum directly.
        S_DRAIN: begin
          r_state     <= S_OUT;
          r_out_valid <= 1'b1;
          r_out_data  <= w_scaled_p1;
          r_out_idx   <= ADDR_W'(r_o);
        end

        S_OUT: begin
          if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_o == O_LAST) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              // Next neuron's row starts right after the previous row's end.
              r_state       <= S_MAC;
              r_o           <= r_o + OW'(1);
              r_i           <= '0;
              r_acc         <= '0;
              r_weight_addr <= r_weight_addr + ADDR_W'(1);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.busy        = r_busy;
  assign io_bus.in_ready    = r_in_ready;
  assign io_bus.weight_addr = r_weight_addr;
  assign io_bus.out_valid   = r_out_valid;
  assign io_bus.out_data    = r_out_data;
  assign io_bus.out_idx     = r_out_idx;
  assign io_bus.done        = r_done;

  // The linear sweep must stay inside the weight ROM.
  a_addr_range: assert property (@(posedge clk) disable iff (rst)
    r_weight_addr <= ADDR_MAX);

  // A stalled result is held unchanged until the consumer takes it.
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (r_out_valid && !io_bus.out_ready) |=>
      (r_out_valid && $stable(r_out_data) && $stable(r_out_idx)));

endmodule

// File: tb/tb_linear_mac_reader.sv
// tb_linear_mac_reader: randomized bench for linear_mac_reader with a
// frame-level reference model (features, ROM image, per-neuron sums) and a
// per-cycle compare process.
`timescale 1ns/1ps
module tb_linear_mac_reader;
  localparam int IN_DIM  = 40;
  localparam int OUT_DIM = 10;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 32;
  localparam int FRAC    = 24;
  localparam int NW      = IN_DIM * OUT_DIM;
  localparam int LAT     = IN_DIM + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  linear_mac_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  linear_mac_reader #(
    .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .FRAC(FRAC), .ACC_W(64)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic signed [31:0] rom [NW];
  logic signed [31:0] xs  [IN_DIM];

  bit          mon_en  = 0;
  bit          m_act   = 0;
  int          m_nin   = 0;
  int          m_o     = 0;
  int          m_gap   = 0;
  bit          m_done  = 0;
  logic signed [31:0] m_x [IN_DIM];
  logic [31:0] m_y [OUT_DIM];
  logic [31:0] got [OUT_DIM];
  int          done_cnt   = 0;
  int          stall_seen = 0;
  bit          prev_hold  = 0;
  logic [31:0] prev_data;
  logic [8:0]  prev_idx;
  bit          t3_en   = 0;
  bit          or_rand = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] scale(input longint acc);
    longint sh;
    sh = acc >>> FRAC;
`ifdef LINEAR_MAC_SAT_EN
    if (sh > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (sh < -64'sd2147483648) return 32'h80000000;
`endif
    return sh[31:0];
  endfunction

  task automatic compute_y();
    for (int o = 0; o < OUT_DIM; o++) begin
      longint acc;
      acc = 0;
      for (int i = 0; i < IN_DIM; i++)
        acc += longint'(m_x[i]) * longint'(rom[o*IN_DIM + i]);
      m_y[o] = scale(acc);
    end
  endtask

  // Weight ROM: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    int a;
    a = int'(bus.weight_addr);
    if (a < NW) bus.weight_data <= rom[a];
    else        bus.weight_data <= 32'hDEADBEEF;
  end

  // Compare against the model, then advance the model by the next edge.
  always @(negedge clk) begin
    bit exp_ov;
    exp_ov = m_act && (m_nin == IN_DIM) && (m_gap >= LAT);
    if (mon_en) begin
      chk("busy",      bus.busy,      m_act);
      chk("in_ready",  bus.in_ready,  m_act && (m_nin < IN_DIM));
      chk("out_valid", bus.out_valid, exp_ov);
      chk("done",      bus.done,      m_done);
      if (exp_ov) begin
        chk("out_data", bus.out_data, m_y[m_o]);
        chk("out_idx",  bus.out_idx,  m_o);
      end
      if (m_act && m_nin == IN_DIM)
        chk("weight_addr", bus.weight_addr,
            m_o*IN_DIM + ((m_gap < IN_DIM) ? m_gap : IN_DIM-1));
      if (prev_hold)
        chk("out_hold", {bus.out_valid, bus.out_idx, bus.out_data},
            {1'b1, prev_idx, prev_data});
      if (bus.done === 1'b1) done_cnt++;
    end
    prev_hold = mon_en && !rst && (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
    prev_data = bus.out_data;
    prev_idx  = bus.out_idx;
    m_done    = 0;
    if (rst) begin
      m_act = 0; m_nin = 0; m_o = 0; m_gap = 0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act = 1; m_nin = 0; m_o = 0; m_gap = 0;
      end
    end else if (m_nin < IN_DIM) begin
      if (bus.in_valid) begin
        m_x[m_nin] = bus.in_data;
        m_nin++;
        if (m_nin == IN_DIM) begin
          compute_y();
          m_gap = 0;
        end
      end
    end else if (m_gap >= LAT) begin
      if (m_o == 3 && !bus.out_ready) stall_seen++;
      if (bus.out_ready) begin
        got[m_o] = bus.out_data;
        if (m_o == OUT_DIM-1) begin
          m_act = 0; m_done = 1;
        end else begin
          m_o++; m_gap = 0;
        end
      end
    end else begin
      m_gap++;
    end
  end

  // Consumer back-pressure.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (t3_en && m_act && m_nin == IN_DIM && m_o == 3 && stall_seen < 5)
        bus.out_ready = 1'b0;
      else if (or_rand)
        bus.out_ready = ($urandom_range(3) != 0);
      else
        bus.out_ready = 1'b1;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic feed(input bit gaps);
    for (int i = 0; i < IN_DIM; i++) begin
      bit hs;
      int n;
      if (gaps) repeat ($urandom_range(2)) begin
        bus.in_valid = 1'b0; @(posedge clk); #1;
      end
      bus.in_data = xs[i]; bus.in_valid = 1'b1; hs = 0; n = 0;
      while (!hs && n < 200) begin
        @(negedge clk); hs = bus.in_ready;
        @(posedge clk); #1; n++;
      end
      chk("feed_hs", hs, 1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_act && n < 5000) begin @(posedge clk); n++; end
    chk("frame_complete", m_act, 0);
  endtask

  task automatic run_frame(input bit gaps);
    int d0;
    d0 = done_cnt;
    pulse_start();
    feed(gaps);
    wait_idle();
    repeat (2) @(negedge clk); #1;
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk); #1;
    chk({tag, "_busy"},      bus.busy,        0);
    chk({tag, "_in_ready"},  bus.in_ready,    0);
    chk({tag, "_addr"},      bus.weight_addr, 0);
    chk({tag, "_out_valid"}, bus.out_valid,   0);
    chk({tag, "_out_data"},  bus.out_data,    0);
    chk({tag, "_out_idx"},   bus.out_idx,     0);
    chk({tag, "_done"},      bus.done,        0);
  endtask

  task automatic fill_const(input logic [31:0] xv, input logic [31:0] wv);
    for (int i = 0; i < IN_DIM; i++) xs[i] = xv;
    for (int k = 0; k < NW; k++) rom[k] = wv;
  endtask

  task automatic fill_rand(input bit full);
    for (int i = 0; i < IN_DIM; i++)
      xs[i] = full ? $urandom : ($urandom_range(32'h0800_0000) - 32'h0400_0000);
    for (int k = 0; k < NW; k++)
      rom[k] = full ? $urandom : ($urandom_range(32'h0800_0000) - 32'h0400_0000);
  endtask

  task automatic check_t1(input string tag);
    chk({tag, "_model_y0"}, m_y[0], 32'h14000000);
    for (int o = 0; o < OUT_DIM; o++)
      chk({tag, "_y"}, got[o], 32'h14000000);
    chk({tag, "_last_addr"}, bus.weight_addr, NW-1);
  endtask

  initial begin
    int d0;
    int n;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    fill_const(32'h0, 32'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk); #1 rst = 1'b0;
    mon_en = 1;
    check_zero("reset");

    // T1/T2: constant frame, address sweep checked every cycle.
    fill_const(32'h01000000, 32'h00800000);
    or_rand = 0;
    run_frame(0);
    check_t1("t1");

    // T3: five-cycle stall on neuron 3.
    fill_rand(0);
    stall_seen = 0; t3_en = 1;
    run_frame(1);
    t3_en = 0;
    chk("t3_stall_cycles", stall_seen, 5);

    // T4: overflowing sum.
    fill_const(32'h64000000, 32'h64000000);
    run_frame(0);
`ifdef LINEAR_MAC_SAT_EN
    chk("t4_y0", got[0], 32'h7FFFFFFF);
    chk("t4_y9", got[9], 32'h7FFFFFFF);
`else
    chk("t4_y0", got[0], 32'h80000000);
    chk("t4_y9", got[9], 32'h80000000);
`endif

    // T5: reset during MAC of neuron 2, then a clean frame.
    fill_const(32'h01000000, 32'h00800000);
    d0 = done_cnt;
    pulse_start();
    feed(0);
    n = 0;
    while (!(m_o == 2 && m_gap >= 10) && n < 3000) begin @(posedge clk); n++; end
    chk("t5_reach_o2", m_o, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_zero("t5");
    repeat (3) @(negedge clk); #1;
    chk("t5_no_done", done_cnt - d0, 0);
    run_frame(0);
    check_t1("t5");

    // T6: stray start / in_valid outside their windows.
    fill_const(32'h01000000, 32'h00800000);
    d0 = done_cnt;
    @(posedge clk); #1 bus.in_valid = 1'b1; bus.in_data = $urandom;
    repeat (3) @(posedge clk); #1 bus.in_valid = 1'b0;
    pulse_start();
    feed(1);
    repeat (5) @(posedge clk); #1;
    bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_data = $urandom;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (3) @(posedge clk); #1 bus.in_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk); #1;
    chk("t6_done_pulses", done_cnt - d0, 1);
    check_t1("t6");

    // Random frames with input gaps and random back-pressure.
    or_rand = 1;
    for (int f = 0; f < 5; f++) begin
      fill_rand(f[0]);
      run_frame(1);
    end
    or_rand = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
